// File: rtl/vga_pkg.sv
// vga_pkg: tile geometry, selector constants and shared types for the 3x3 tile overlay
package vga_pkg;
  localparam int SEL_COLS = 3;
  localparam int SEL_ROWS = 3;
  localparam int X_1_DIM  = 40;
  localparam int X_2_DIM  = 240;
  localparam int X_3_DIM  = 440;
  localparam int Y_1_DIM  = 40;
  localparam int Y_2_DIM  = 200;
  localparam int Y_3_DIM  = 360;
  localparam int A_side   = 180;
  localparam int B_side   = 140;

  typedef enum logic {BROWSE, LOCKED} sel_state_t;

  typedef struct packed {
    logic cancel;
    logic confirm;
    logic up;
    logic down;
    logic left;
    logic right;
  } sel_req_t;

  function automatic logic signed [11:0] tile_x(input logic [1:0] c);
    return c == 2'd0 ? 12'(X_1_DIM) : c == 2'd1 ? 12'(X_2_DIM) : 12'(X_3_DIM);
  endfunction

  function automatic logic signed [11:0] tile_y(input logic [1:0] r);
    return r == 2'd0 ? 12'(Y_1_DIM) : r == 2'd1 ? 12'(Y_2_DIM) : 12'(Y_3_DIM);
  endfunction
endpackage

// File: rtl/vga_if.sv
// vga_if: VGA timing plus pixel colour stream between renderer stages
interface vga_if;
  logic [10:0] vcount;
  logic [10:0] hcount;
  logic        vsync;
  logic        vblnk;
  logic        hsync;
  logic        hblnk;
  logic [11:0] rgb;
  modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
  modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

// File: rtl/tile_frame_hit.sv
// tile_frame_hit: true when the pixel lies in the FRAME_W-wide ring just outside the selected tile
module tile_frame_hit
  import vga_pkg::*;
#(
  parameter int FRAME_W = 3
) (
  input  logic [10:0] hcount,
  input  logic [10:0] vcount,
  input  logic [1:0]  col,
  input  logic [1:0]  row,
  output logic        hit
);
  localparam logic signed [11:0] FW = 12'(FRAME_W);
  localparam logic signed [11:0] AW = 12'(A_side);
  localparam logic signed [11:0] BH = 12'(B_side);
  logic signed [11:0] x, y, xc, yc;
  logic outer, inner;
  // signed compares keep tiles near the screen edge from wrapping below zero
  always_comb begin
    x     = $signed({1'b0, hcount});
    y     = $signed({1'b0, vcount});
    xc    = tile_x(col);
    yc    = tile_y(row);
    outer = x >= xc - FW && x <= xc + AW + FW && y >= yc - FW && y <= yc + BH + FW;
    inner = x >= xc && x <= xc + AW && y >= yc && y <= yc + BH;
    hit   = outer & ~inner;
  end
endmodule

// File: rtl/tile_select_overlay.sv
// tile_select_overlay: button-driven tile cursor with lock/blink, drawn as a frame on the VGA stream
module tile_select_overlay
  import vga_pkg::*;
#(
  parameter int          FRAME_W      = 3,
  parameter int          BLINK_FRAMES = 16,
  parameter logic [11:0] COLOR_BROWSE = 12'hFF0,
  parameter logic [11:0] COLOR_LOCK   = 12'h0F0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_confirm,
  input  logic       btn_cancel,
  vga_if.in          in,
  vga_if.out         out,
  output logic [3:0] sel_idx,
  output logic       sel_locked,
  output logic       sel_valid
);
  localparam int BW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
  localparam logic [1:0] COL_LAST = 2'(SEL_COLS - 1);
  localparam logic [1:0] ROW_LAST = 2'(SEL_ROWS - 1);

  sel_state_t    state_q, state_d;
  sel_req_t      pend_q, pend_d, btn;
  logic [1:0]    col_q, col_d, row_q, row_d;
  logic [BW-1:0] blink_q, blink_d;
  logic          vis_q, vis_d, valid_q, valid_d;
  logic          frame_start, hit, stay_locked;
  logic [10:0]   hcount_q, vcount_q;
  logic          hsync_q, hblnk_q, vsync_q, vblnk_q;
  logic [11:0]   rgb_q, rgb_d;

  assign btn = {btn_cancel, btn_confirm, btn_up, btn_down, btn_left, btn_right};

  tile_frame_hit #(.FRAME_W(FRAME_W)) u_hit (
    .hcount(in.hcount),
    .vcount(in.vcount),
    .col   (col_q),
    .row   (row_q),
    .hit   (hit)
  );

  // collect button requests and apply them only at vblnk rising, so a frame never shows a torn cursor
  always_comb begin
    frame_start = in.vblnk & ~vblnk_q;
    pend_d      = frame_start ? btn : sel_req_t'(pend_q | btn);
    state_d     = state_q;
    valid_d     = 1'b0;
    col_d       = col_q;
    row_d       = row_q;
    blink_d     = blink_q;
    vis_d       = vis_q;
    stay_locked = 1'b0;
    if (frame_start) begin
      if (state_q == LOCKED && pend_q.cancel) state_d = BROWSE;
      else if (state_q == BROWSE && pend_q.confirm) state_d = LOCKED;
      valid_d     = state_q == BROWSE && state_d == LOCKED;
      stay_locked = state_q == LOCKED && state_d == LOCKED;
      if (state_d == BROWSE) begin
        row_d = pend_q.up   ? (row_q == 2'd0 ? row_q : row_q - 2'd1) :
                pend_q.down ? (row_q == ROW_LAST ? row_q : row_q + 2'd1) : row_q;
        col_d = pend_q.left  ? (col_q == 2'd0 ? COL_LAST : col_q - 2'd1) :
                pend_q.right ? (col_q == COL_LAST ? 2'd0 : col_q + 2'd1) : col_q;
      end
      blink_d = stay_locked ? (blink_q == BLINK_LAST ? '0 : blink_q + 1'b1) : '0;
      vis_d   = stay_locked ? vis_q ^ (blink_q == BLINK_LAST) : 1'b1;
    end
  end

  // frame colour replaces the pixel on the ring, outside blanking, unless the locked blink is in its dark half
  always_comb
    rgb_d = (in.hblnk | in.vblnk | ~hit) ? in.rgb :
            state_q == BROWSE ? COLOR_BROWSE :
            vis_q ? COLOR_LOCK : in.rgb;

  // selector state and the one-cycle output register stage
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q  <= BROWSE;
      pend_q   <= '0;
      col_q    <= '0;
      row_q    <= '0;
      blink_q  <= '0;
      vis_q    <= 1'b1;
      valid_q  <= 1'b0;
      hcount_q <= '0;
      vcount_q <= '0;
      hsync_q  <= 1'b0;
      hblnk_q  <= 1'b0;
      vsync_q  <= 1'b0;
      vblnk_q  <= 1'b0;
      rgb_q    <= '0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      col_q    <= col_d;
      row_q    <= row_d;
      blink_q  <= blink_d;
      vis_q    <= vis_d;
      valid_q  <= valid_d;
      hcount_q <= in.hcount;
      vcount_q <= in.vcount;
      hsync_q  <= in.hsync;
      hblnk_q  <= in.hblnk;
      vsync_q  <= in.vsync;
      vblnk_q  <= in.vblnk;
      rgb_q    <= rgb_d;
    end

  assign out.hcount = hcount_q;
  assign out.vcount = vcount_q;
  assign out.hsync  = hsync_q;
  assign out.hblnk  = hblnk_q;
  assign out.vsync  = vsync_q;
  assign out.vblnk  = vblnk_q;
  assign out.rgb    = rgb_q;
  assign sel_idx    = 4'(row_q) * 4'(SEL_COLS) + 4'(col_q);
  assign sel_locked = state_q == LOCKED;
  assign sel_valid  = valid_q;
endmodule
